// File: rtl/day34_mux_2x1.sv
// 2:1 WIDTH-bit data mux: combinational Out plus a one-cycle registered copy with valid and sel-toggle count.
// Optional registered even-parity output out_parity is enabled by defining MUX_PARITY_EN.
module day34_mux_2x1 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] sel_toggle_cnt
`ifdef MUX_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mux_val;
  logic             sel_b;
  logic [WIDTH-1:0] out_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_sel_q, last_sel_d;

  // An if-statement (not ?:) so an unknown sel resolves to A rather than X.
  always_comb begin
    mux_val = A;
    sel_b   = 1'b0;
    if (sel) begin
      mux_val = B;
      sel_b   = 1'b1;
    end
  end

  assign Out = mux_val;

  always_comb begin
    out_d      = out_q;
    valid_d    = in_valid;
    cnt_d      = cnt_q;
    last_sel_d = last_sel_q;
    if (in_valid) begin
      out_d      = mux_val;
      last_sel_d = sel_b;
      if ((sel_b != last_sel_q) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
      last_sel_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      last_sel_q <= last_sel_d;
    end
  end

  assign out_valid      = valid_q;
  assign sel_toggle_cnt = cnt_q;

`ifdef MUX_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (in_valid) begin
      parity_d = ^mux_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_day34_mux_2x1.sv
// Self-checking bench for day34_mux_2x1: directed cases plus randomized streaming against a transaction-level model.
// A second instance with a narrow counter exercises toggle-count saturation.
module tb_day34_mux_2x1;
  localparam int WIDTH   = 32;
  localparam int CNT_W   = 16;
  localparam int SAT_W   = 4;
  localparam int SAT_MAX = (1 << SAT_W) - 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] A, B;
  logic             sel, in_valid;
  logic [WIDTH-1:0] Out, out_q, sat_out, sat_out_q;
  logic             out_valid, sat_out_valid;
  logic [CNT_W-1:0] sel_toggle_cnt;
  logic [SAT_W-1:0] sat_cnt;
`ifdef MUX_PARITY_EN
  logic             out_parity, sat_parity;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state: what the spec says the outputs should be
  logic [WIDTH-1:0] exp_q;
  logic             exp_valid;
  int               exp_cnt, exp_sat_cnt;
  logic             prev_sel;

  always #5 clk = ~clk;

  day34_mux_2x1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .sel(sel), .in_valid(in_valid),
    .Out(Out), .out_q(out_q), .out_valid(out_valid), .sel_toggle_cnt(sel_toggle_cnt)
`ifdef MUX_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  day34_mux_2x1 #(.WIDTH(WIDTH), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .sel(sel), .in_valid(in_valid),
    .Out(sat_out), .out_q(sat_out_q), .out_valid(sat_out_valid), .sel_toggle_cnt(sat_cnt)
`ifdef MUX_PARITY_EN
    , .out_parity(sat_parity)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  task automatic model_reset();
    exp_q       = '0;
    exp_valid   = 1'b0;
    exp_cnt     = 0;
    exp_sat_cnt = 0;
    prev_sel    = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    check_val({tag, "_q"}, 64'(out_q), 64'(exp_q));
    check_val({tag, "_valid"}, 64'(out_valid), 64'(exp_valid));
    check_val({tag, "_cnt"}, 64'(sel_toggle_cnt), 64'(exp_cnt));
    check_val({tag, "_satcnt"}, 64'(sat_cnt), 64'(exp_sat_cnt));
`ifdef MUX_PARITY_EN
    check_val({tag, "_par"}, 64'(out_parity), 64'($countones(exp_q) % 2));
`endif
  endtask

  // One clock with the given inputs; the model advances at the edge, checks follow 1 time unit later.
  task automatic cycle(input logic v, input logic s, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input string tag);
    A = a; B = b; sel = s; in_valid = v;
    @(posedge clk);
    if (rst_n) begin
      exp_valid = v;
      if (v) begin
        exp_q = s ? b : a;
        if (s != prev_sel) begin
          if (exp_cnt < CNT_MAX) exp_cnt++;
          if (exp_sat_cnt < SAT_MAX) exp_sat_cnt++;
        end
        prev_sel = s;
      end
    end
    #1;
    check_val({tag, "_out"}, 64'(Out), 64'(s ? b : a));
    check_regs(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             rs, rv;

    rst_n = 1'b0; A = 32'h0000_1234; B = 32'h0000_ABCD; sel = 1'b0; in_valid = 1'b0;
    model_reset();

    // Combinational select while held in reset
    #1;
    check_val("comb_sel0", 64'(Out), 64'h0000_1234);
    check_regs("rst_state");
    sel = 1'b1;
    #1;
    check_val("comb_sel1", 64'(Out), 64'h0000_ABCD);

    for (int i = 0; i < 10; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      A = ra; B = rb; sel = rs;
      #10;
      check_val($sformatf("sweep%0d", i), 64'(Out), 64'(rs ? rb : ra));
    end

    // Registered latency and hold
    do_reset();
    cycle(1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF, "lat_cap");
    cycle(1'b0, 1'b0, 32'h1111_1111, 32'h2222_2222, "lat_hold");

    // Toggle counter: 1,1,0,1,0 -> 4, then invalid toggles leave it alone
    do_reset();
    cycle(1'b1, 1'b1, 32'hA0, 32'hB0, "tog1");
    cycle(1'b1, 1'b1, 32'hA1, 32'hB1, "tog2");
    cycle(1'b1, 1'b0, 32'hA2, 32'hB2, "tog3");
    cycle(1'b1, 1'b1, 32'hA3, 32'hB3, "tog4");
    cycle(1'b1, 1'b0, 32'hA4, 32'hB4, "tog5");
    check_val("tog_total", 64'(sel_toggle_cnt), 64'd4);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'(i % 2 == 0), 32'hC0 + i, 32'hD0 + i, "tog_inv");
    check_val("tog_inv_total", 64'(sel_toggle_cnt), 64'd4);

    // Randomized streaming with valid gaps
    for (int i = 0; i < 40; i++) begin
      rv = 1'($urandom_range(0, 3) != 0);
      rs = 1'($urandom_range(0, 1));
      cycle(rv, rs, $urandom, $urandom, $sformatf("rnd%0d", i));
    end

    // Narrow-counter instance must stop at its maximum
    for (int i = 0; i < 2 * SAT_MAX; i++) cycle(1'b1, 1'(i % 2 == 0), 32'h5 + i, 32'h9 + i, "sat");
    check_val("sat_total", 64'(sat_cnt), 64'(SAT_MAX));

    // Asynchronous reset between edges
    cycle(1'b1, 1'b1, 32'h1357_9BDF, 32'hFEED_F00D, "pre_arst");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_regs("arst");
    A = 32'h0BAD_CAFE; B = 32'h600D_F00D; sel = 1'b1;
    #1;
    check_val("arst_out", 64'(Out), 64'h600D_F00D);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 32'h0000_0042, 32'h0, "post_arst");

`ifdef MUX_PARITY_EN
    cycle(1'b1, 1'b0, 32'h0000_0007, 32'h0, "par7");
    check_val("par7_val", 64'(out_parity), 64'd1);
    cycle(1'b1, 1'b1, 32'h0, 32'h0000_0003, "par3");
    check_val("par3_val", 64'(out_parity), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
